// File: rtl/sound_glu_host_master.sv
`default_nettype none
// ============================================================================
// Module  : sound_glu_host_master
// Purpose : Host-port initiator that expands byte/burst requests into the
//           GLU ctrl / address / busy-poll / dummy / data access sequence.
// Rev     : 1.0  initial release
// ============================================================================
module sound_glu_host_master #(
   parameter int         POLL_LIMIT  = 255,
   parameter logic [3:0] VOL_DEFAULT = 4'hF
) (
   input  logic        CLK_14M,
   input  logic        reset,
   input  logic        ph0_en,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic        req_ram,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_len,
   input  logic [7:0]  req_data,
   output logic        wdata_ack,
   input  logic        vol_override,
   input  logic [3:0]  vol_in,
   output logic        resp_valid,
   output logic [7:0]  resp_data,
   output logic        done,
   output logic        error,
   output logic        select,
   output logic        wr,
   output logic [1:0]  host_addr,
   output logic [7:0]  host_data_out,
   input  logic [7:0]  host_data_in
);

   localparam int         PW        = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);
   localparam logic [1:0] c_reg_ctl = 2'd0;
   localparam logic [1:0] c_reg_dat = 2'd1;
   localparam logic [1:0] c_reg_adl = 2'd2;
   localparam logic [1:0] c_reg_adh = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_CTRL, S_ADRL, S_ADRH, S_POLL, S_DUMMY, S_DATA, S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [7:0]     ctrl_q, ctrl_d;
   logic [15:0]    addr_q, addr_d;
   logic           txn_wr_q, txn_wr_d;
   logic           txn_ram_q, txn_ram_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [7:0]     data_q, data_d;
   logic           first_q, first_d;
   logic [PW-1:0]  poll_q, poll_d;
   logic           ack_seen_q, ack_seen_d;
   logic           resp_valid_q, resp_valid_d;
   logic [7:0]     resp_data_q, resp_data_d;
   logic           error_q, error_d;
   logic           wr_q, wr_d;
   logic [1:0]     host_addr_q, host_addr_d;
   logic [7:0]     host_data_out_q, host_data_out_d;
   logic           w_access;
   logic [PW-1:0]  w_poll_inc;

   always_comb begin
      state_d         = state_q;
      ctrl_d          = ctrl_q;
      addr_d          = addr_q;
      txn_wr_d        = txn_wr_q;
      txn_ram_d       = txn_ram_q;
      cnt_d           = cnt_q;
      first_d         = first_q;
      poll_d          = poll_q;
      ack_seen_d      = 1'b0;
      resp_valid_d    = 1'b0;
      resp_data_d     = resp_data_q;
      error_d         = error_q;
      w_poll_inc      = poll_q + PW'(1);
      w_access        = (state_q != S_IDLE) && (state_q != S_DONE);
      // The byte after an acknowledged write is taken one cycle after the ack.
      data_d          = ack_seen_q ? req_data : data_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               ctrl_d    = {1'b0, req_ram, 1'b1, 1'b0, vol_override ? vol_in : VOL_DEFAULT};
               addr_d    = req_addr;
               txn_wr_d  = req_wr;
               txn_ram_d = req_ram;
               cnt_d     = req_len;
               data_d    = req_data;
               first_d   = 1'b1;
               poll_d    = '0;
               error_d   = 1'b0;
               state_d   = S_CTRL;
            end
         end
         S_CTRL:  if (ph0_en) state_d = S_ADRL;
         S_ADRL:  if (ph0_en) state_d = txn_ram_q ? S_ADRH : S_POLL;
         S_ADRH:  if (ph0_en) state_d = S_POLL;
         S_POLL: begin
            if (ph0_en) begin
               if (host_data_in[7]) begin
                  if (w_poll_inc == PW'(POLL_LIMIT)) begin
                     poll_d  = '0;
                     error_d = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     poll_d = w_poll_inc;
                  end
               end else begin
                  poll_d  = '0;
                  state_d = (!txn_wr_q && first_q) ? S_DUMMY : S_DATA;
               end
            end
         end
         S_DUMMY: if (ph0_en) state_d = S_DATA;
         S_DATA: begin
            if (ph0_en) begin
               first_d = 1'b0;
               if (txn_wr_q) begin
                  ack_seen_d = 1'b1;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = host_data_in;
               end
               if (cnt_q == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q - 8'd1;
                  state_d = S_POLL;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Bus fields are registered from the upcoming state so they are stable all cycle.
      wr_d            = 1'b0;
      host_addr_d     = c_reg_ctl;
      host_data_out_d = 8'h00;
      case (state_d)
         S_CTRL:  begin wr_d = 1'b1; host_addr_d = c_reg_ctl; host_data_out_d = ctrl_d;       end
         S_ADRL:  begin wr_d = 1'b1; host_addr_d = c_reg_adl; host_data_out_d = addr_d[7:0];  end
         S_ADRH:  begin wr_d = 1'b1; host_addr_d = c_reg_adh; host_data_out_d = addr_d[15:8]; end
         S_POLL:  host_addr_d = c_reg_ctl;
         S_DUMMY: host_addr_d = c_reg_dat;
         S_DATA: begin
            wr_d        = txn_wr_d;
            host_addr_d = c_reg_dat;
            if (txn_wr_d) host_data_out_d = data_d;
         end
         default: host_addr_d = c_reg_ctl;
      endcase
   end

   always_ff @(posedge CLK_14M) begin
      if (reset) begin
         state_q         <= S_IDLE;
         ctrl_q          <= 8'h00;
         addr_q          <= 16'h0000;
         txn_wr_q        <= 1'b0;
         txn_ram_q       <= 1'b0;
         cnt_q           <= 8'h00;
         data_q          <= 8'h00;
         first_q         <= 1'b0;
         poll_q          <= '0;
         ack_seen_q      <= 1'b0;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= 8'h00;
         error_q         <= 1'b0;
         wr_q            <= 1'b0;
         host_addr_q     <= 2'd0;
         host_data_out_q <= 8'h00;
      end else begin
         state_q         <= state_d;
         ctrl_q          <= ctrl_d;
         addr_q          <= addr_d;
         txn_wr_q        <= txn_wr_d;
         txn_ram_q       <= txn_ram_d;
         cnt_q           <= cnt_d;
         data_q          <= data_d;
         first_q         <= first_d;
         poll_q          <= poll_d;
         ack_seen_q      <= ack_seen_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         error_q         <= error_d;
         wr_q            <= wr_d;
         host_addr_q     <= host_addr_d;
         host_data_out_q <= host_data_out_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign select        = w_access && ph0_en;
   assign wdata_ack     = (state_q == S_DATA) && txn_wr_q && ph0_en;
   assign done          = (state_q == S_DONE);
   assign error         = error_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign wr            = wr_q;
   assign host_addr     = host_addr_q;
   assign host_data_out = host_data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sound_glu_host_master.sv
`default_nettype none
// Scoreboard bench for sound_glu_host_master: a GLU host-port model answers the
// DUT, expected accesses/responses/done flags are queued and popped by a monitor.
module tb_sound_glu_host_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, ph0_en = 1'b0;
   logic        req_valid = 1'b0, req_valid_b = 1'b0, req_wr = 1'b0, req_ram = 1'b0;
   logic [15:0] req_addr = 16'h0;
   logic [7:0]  req_len = 8'h0, req_data = 8'h0;
   logic        vol_override = 1'b0;
   logic [3:0]  vol_in = 4'h0;

   logic       req_ready, wdata_ack, resp_valid, done, error, select, wr;
   logic [7:0] resp_data, host_data_out, host_data_in;
   logic [1:0] host_addr;

   logic       req_ready_b, wdata_ack_b, resp_valid_b, done_b, error_b, select_b, wr_b;
   logic [7:0] resp_data_b, host_data_out_b, host_data_in_b;
   logic [1:0] host_addr_b;

   sound_glu_host_master u_dut (
      .CLK_14M(clk), .reset(reset), .ph0_en(ph0_en),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_ram(req_ram),
      .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .wdata_ack(wdata_ack),
      .vol_override(vol_override), .vol_in(vol_in),
      .resp_valid(resp_valid), .resp_data(resp_data), .done(done), .error(error),
      .select(select), .wr(wr), .host_addr(host_addr),
      .host_data_out(host_data_out), .host_data_in(host_data_in)
   );

   sound_glu_host_master #(.POLL_LIMIT(4)) u_dut_lim (
      .CLK_14M(clk), .reset(reset), .ph0_en(ph0_en),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr), .req_ram(req_ram),
      .req_addr(req_addr), .req_len(req_len), .req_data(req_data), .wdata_ack(wdata_ack_b),
      .vol_override(vol_override), .vol_in(vol_in),
      .resp_valid(resp_valid_b), .resp_data(resp_data_b), .done(done_b), .error(error_b),
      .select(select_b), .wr(wr_b), .host_addr(host_addr_b),
      .host_data_out(host_data_out_b), .host_data_in(host_data_in_b)
   );

   // ---------------- scoring ----------------
   int n_vec = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic extra(input string name, input logic [31:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: unexpected output 0x%0h, nothing expected (t=%0t)", name, act, $time);
   endtask

   // ---------------- ph0_en generator ----------------
   int ph_div = 1, ph_cnt = 0;
   always @(posedge clk) begin
      #1;
      ph_cnt = (ph_cnt + 1 >= ph_div) ? 0 : ph_cnt + 1;
      ph0_en = (ph_cnt == 0);
   end

   // ---------------- GLU model for u_dut ----------------
   logic [15:0] g_addr = 16'h0;
   logic [7:0]  g_rlatch = 8'h0;
   int          poll_seen = 0, busy_n = 0;
   logic        glu_busy;

   function automatic logic [7:0] ram_at(input logic [15:0] a);
      case (a)
         16'h12FF: return 8'hA1;
         16'h1300: return 8'hB2;
         16'h1301: return 8'hC3;
         default:  return a[7:0] ^ 8'h5A;
      endcase
   endfunction

   assign glu_busy     = (poll_seen < busy_n);
   assign host_data_in = (host_addr == 2'd0) ? {glu_busy, 7'h00} : g_rlatch;

   always @(posedge clk) begin
      if (select) begin
         if (wr) begin
            case (host_addr)
               2'd0:    poll_seen <= 0;
               2'd1:    begin g_addr <= g_addr + 16'd1; poll_seen <= 0; end
               2'd2:    g_addr[7:0]  <= host_data_out;
               default: g_addr[15:8] <= host_data_out;
            endcase
         end else if (host_addr == 2'd0) begin
            poll_seen <= poll_seen + 1;
         end else begin
            g_rlatch  <= ram_at(g_addr);
            g_addr    <= g_addr + 16'd1;
            poll_seen <= 0;
         end
      end
   end

   // ---------------- GLU model for u_dut_lim (busy can be stuck) ----------------
   logic b_stuck = 1'b0;
   assign host_data_in_b = (host_addr_b == 2'd0) ? {b_stuck, 7'h00} : 8'h00;

   int   b_polls = 0, b_data = 0, b_dones = 0;
   logic b_err_at_done = 1'b0;
   always @(negedge clk) begin
      if (select_b && !wr_b && host_addr_b == 2'd0) b_polls++;
      if (select_b && host_addr_b == 2'd1) b_data++;
      if (done_b) begin b_dones++; b_err_at_done = error_b; end
   end

   // ---------------- scoreboard monitor for u_dut ----------------
   typedef struct packed { logic w; logic [1:0] a; logic [7:0] d; } acc_t;
   acc_t       exp_acc[$];
   logic [7:0] exp_resp[$];
   logic       exp_done[$];
   int         ack_cnt = 0, done_cnt = 0;

   always @(negedge clk) begin : mon
      acc_t       e;
      logic [7:0] r;
      logic       de;
      if (select) begin
         check("select_needs_ph0", ph0_en, 1'b1);
         if (exp_acc.size() == 0) extra("access", {wr, host_addr, host_data_out});
         else begin
            e = exp_acc.pop_front();
            check("acc_wr", wr, e.w);
            check("acc_reg", host_addr, e.a);
            if (e.w) check("acc_wdata", host_data_out, e.d);
         end
      end
      if (resp_valid) begin
         if (exp_resp.size() == 0) extra("resp", resp_data);
         else begin r = exp_resp.pop_front(); check("resp_data", resp_data, r); end
      end
      if (done) begin
         done_cnt++;
         if (exp_done.size() == 0) extra("done", error);
         else begin de = exp_done.pop_front(); check("done_error", error, de); end
      end
      if (wdata_ack) ack_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0] wbytes[$];

   function automatic void pa(input logic w, input logic [1:0] a, input logic [7:0] d);
      exp_acc.push_back({w, a, d});
   endfunction

   task automatic issue(input logic w, input logic ram, input logic [15:0] a, input logic [7:0] len,
                        input logic [7:0] d, input logic vo, input logic [3:0] vi, input logic to_b);
      @(posedge clk); #1;
      req_wr = w; req_ram = ram; req_addr = a; req_len = len; req_data = d;
      vol_override = vo; vol_in = vi;
      if (to_b) req_valid_b = 1'b1; else req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_valid_b = 1'b0;
   endtask

   // Plays the write client and waits for done; stop_ack > 0 returns on that ack.
   task automatic run_txn(input int budget, input int stop_ack);
      int acks = 0;
      bit ended = 0;
      for (int c = 0; c < budget && !ended; c++) begin
         @(negedge clk);
         if (done) ended = 1;
         else if (wdata_ack) begin
            acks++;
            if (stop_ack != 0 && acks == stop_ack) ended = 1;
            else begin
               @(posedge clk); #1;
               if (wbytes.size() > 0) req_data = wbytes.pop_front();
            end
         end
      end
      if (!ended) check("txn_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_b(input int budget);
      int start = b_dones;
      for (int c = 0; c < budget && b_dones == start; c++) @(negedge clk);
      if (b_dones == start) check("lim_timeout", 32'd0, 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   int a0;
   initial begin
      repeat (3) @(negedge clk);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_select", select, 1'b0);
      check("rst_wr", wr, 1'b0);
      check("rst_wdata_ack", wdata_ack, 1'b0);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_host_addr", host_addr, 2'd0);
      check("rst_host_data_out", host_data_out, 8'h00);
      check("rst_resp_data", resp_data, 8'h00);
      @(posedge clk); #1; reset = 1'b0;

      // DOC write, single byte, default volume
      pa(1, 0, 8'h2F); pa(1, 2, 8'h40); pa(0, 0, 0); pa(1, 1, 8'h3C); exp_done.push_back(0);
      a0 = ack_cnt;
      issue(1, 0, 16'h0040, 8'd0, 8'h3C, 0, 4'h0, 0);
      run_txn(100, 0);
      check("doc_wr_acks", ack_cnt - a0, 1);

      // RAM read burst of three bytes
      pa(1, 0, 8'h6F); pa(1, 2, 8'hFF); pa(1, 3, 8'h12); pa(0, 0, 0); pa(0, 1, 0);
      pa(0, 1, 0); pa(0, 0, 0); pa(0, 1, 0); pa(0, 0, 0); pa(0, 1, 0);
      exp_resp.push_back(8'hA1); exp_resp.push_back(8'hB2); exp_resp.push_back(8'hC3);
      exp_done.push_back(0);
      issue(0, 1, 16'h12FF, 8'd2, 8'h00, 0, 4'h0, 0);
      run_txn(100, 0);

      // Busy for five polls, volume override, ph0_en every other clock
      ph_div = 2; busy_n = 5;
      pa(1, 0, 8'h23); pa(1, 2, 8'h10);
      for (int i = 0; i < 6; i++) pa(0, 0, 0);
      pa(1, 1, 8'h55); exp_done.push_back(0);
      issue(1, 0, 16'h0010, 8'd0, 8'h55, 1, 4'h3, 0);
      run_txn(200, 0);
      busy_n = 0;

      // Sparse ph0_en, RAM write burst of four client bytes
      ph_div = 14;
      pa(1, 0, 8'h6F); pa(1, 2, 8'hFE); pa(1, 3, 8'hFF);
      pa(0, 0, 0); pa(1, 1, 8'h11); pa(0, 0, 0); pa(1, 1, 8'h22);
      pa(0, 0, 0); pa(1, 1, 8'h33); pa(0, 0, 0); pa(1, 1, 8'h44);
      exp_done.push_back(0);
      wbytes = '{8'h22, 8'h33, 8'h44};
      a0 = ack_cnt;
      issue(1, 1, 16'hFFFE, 8'd3, 8'h11, 0, 4'h0, 0);
      run_txn(600, 0);
      check("sparse_acks", ack_cnt - a0, 4);

      // Poll timeout on the POLL_LIMIT=4 instance, then error clears on acceptance
      ph_div = 1; b_stuck = 1'b1;
      issue(0, 0, 16'h0005, 8'd0, 8'h00, 0, 4'h0, 1);
      wait_b(100);
      check("lim_polls", b_polls, 4);
      check("lim_no_data", b_data, 0);
      check("lim_done_error", b_err_at_done, 1'b1);
      @(negedge clk);
      check("lim_error_held", error_b, 1'b1);
      b_stuck = 1'b0;
      issue(1, 0, 16'h0006, 8'd0, 8'h77, 0, 4'h0, 1);
      @(negedge clk);
      check("lim_error_cleared", error_b, 1'b0);
      wait_b(100);
      check("lim_done_ok", b_err_at_done, 1'b0);
      check("lim_data_after", b_data, 1);

      // Reset during the second data byte of a write burst
      pa(1, 0, 8'h6F); pa(1, 2, 8'h00); pa(1, 3, 8'h20);
      pa(0, 0, 0); pa(1, 1, 8'h5A); pa(0, 0, 0); pa(1, 1, 8'h6B);
      wbytes = '{8'h6B, 8'h7C, 8'h8D};
      a0 = done_cnt;
      issue(1, 1, 16'h2000, 8'd3, 8'h5A, 0, 4'h0, 0);
      run_txn(100, 2);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_select", select, 1'b0);
      check("rst_mid_ready", req_ready, 1'b1);
      @(posedge clk); #1; reset = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_mid_no_done", done_cnt - a0, 0);
      wbytes.delete();

      // Normal request after the abort
      pa(1, 0, 8'h6F); pa(1, 2, 8'h00); pa(1, 3, 8'h13); pa(0, 0, 0); pa(0, 1, 0); pa(0, 1, 0);
      exp_resp.push_back(8'hB2); exp_done.push_back(0);
      issue(0, 1, 16'h1300, 8'd0, 8'h00, 0, 4'h0, 0);
      run_txn(100, 0);

      repeat (3) @(negedge clk);
      check("acc_queue_empty", exp_acc.size(), 0);
      check("resp_queue_empty", exp_resp.size(), 0);
      check("done_queue_empty", exp_done.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/sound_glu_host_master.md
Name: sound_glu_host_master

Overview:
- Host-side initiator for the Sound GLU host port (select/wr/host_addr/host_data).
- Turns single or burst requests for DOC register or sound RAM access into the exact GLU register access sequence, all paced by ph0_en:
  - control write
  - address low/high writes
  - busy poll
  - dummy read
  - data accesses
- Lets a sequencer or debug port load sound RAM and program the DOC without CPU involvement; sits between that client and the sound block's host port.

Parameters:
- POLL_LIMIT, 255: maximum consecutive busy-poll reads before the request aborts with an error.
- VOL_DEFAULT, 4'hF: volume nibble written into control bits 3:0 when vol_override is low.

Ports:
- CLK_14M input 1: system clock; all state changes on its rising edge.
- reset input 1: synchronous, active-high.
- ph0_en input 1: one-CLK_14M bus-cycle enable; each GLU access occupies exactly one ph0_en cycle.
- req_valid input 1: request present.
- req_ready output 1: high only in IDLE; a request is accepted when req_valid && req_ready.
- req_wr input 1: 1 = write, 0 = read.
- req_ram input 1: 1 = sound RAM, 0 = DOC register.
- req_addr input 16: start address; DOC uses bits 7:0 only.
- req_len input 8: number of bytes minus 1 (0 = single byte).
- req_data input 8: write data. Sampled at acceptance for byte 0, and at each wdata_ack for later bytes.
- wdata_ack output 1: one-cycle pulse on each completed data write; the client presents the next byte on the following cycle.
- vol_override input 1: select vol_in instead of VOL_DEFAULT.
- vol_in input 4: volume nibble.
- resp_valid output 1: one-cycle pulse per read byte.
- resp_data output 8: read byte, valid with resp_valid.
- done output 1: one-cycle pulse when the request ends.
- error output 1: set on poll timeout, cleared at the next acceptance.
- select output 1: GLU access strobe.
- wr output 1: GLU write strobe.
- host_addr output 2: GLU register address: 0 = control, 1 = data, 2 = addr low, 3 = addr high.
- host_data_out output 8: data to GLU.
- host_data_in input 8: data from GLU; sampled on the same edge as the access.

Behaviour:
- Reset values: state IDLE; req_ready 1; select, wr, wdata_ack, resp_valid, done, error all 0; host_addr 0; host_data_out 0; resp_data 0.
- Access cycle rules:
  - select = 1 exactly during a CLK_14M cycle with ph0_en = 1 and the FSM in an access state; 0 otherwise.
  - wr, host_addr and host_data_out are registered and stable for the whole cycle.
  - A state advances only on an edge where ph0_en = 1.
- Control byte = {1'b0, req_ram, 1'b1 (auto-increment), 1'b0, volume}.
- Control register bit 7 read-back = GLU busy.
- FSM sequence, in order: IDLE -> CTRL (write ctrl) -> ADRL (write addr[7:0]) -> ADRH (write addr[15:8]) -> POLL -> DUMMY -> DATA -> DONE -> IDLE.
  - ADRH is skipped for DOC requests.
  - DUMMY is taken only for reads, and only before byte 0.
- POLL: read control.
  - Bit 7 = 1: stay in POLL and increment the poll counter.
  - Counter reaches POLL_LIMIT: go to DONE with error = 1.
  - Bit 7 = 0: go to DUMMY (read) or DATA (write); the counter clears.
- DUMMY: read data; the value is discarded. GLU read data is one access stale, so the read pipeline must be primed.
- DATA:
  - Write: drive data; pulse wdata_ack.
  - Read: capture host_data_in into resp_data; pulse resp_valid.
  - Byte counter decrements. Counter was 0 -> DONE; otherwise -> POLL. Busy is re-polled before every byte; no address rewrite, since the GLU auto-increments.
- DONE: pulse done for one cycle, return to IDLE.
- Byte counter is 8 bits, loaded with req_len. Address wrap across 16'hFFFF -> 0 is the GLU's job; the master does not track it.
- req_valid during a transaction: ignored (req_ready = 0). Request fields are latched at acceptance, except write data for bytes 1..N.
- Reset mid-transaction: FSM returns to IDLE next edge; select drops immediately; no done pulse. The GLU may be left with a partial address.
- ph0_en stuck low: FSM holds state indefinitely; outputs hold.

Test Plan:
- DOC write: addr 0x40, data 0x3C, len 0, vol_override 0 -> GLU accesses ctrl 0x2F, addr-lo 0x40, poll (busy 0), data write 0x3C. No ADRH. One wdata_ack, one done.
- RAM read burst: addr 0x12FF, len 2, RAM holds 0xA1/0xB2/0xC3 at 0x12FF..0x1301 -> accesses ctrl 0x6F, 0xFF, 0x12, poll, dummy read, three data reads. resp_valid ×3 carrying 0xA1, 0xB2, 0xC3 in order.
- Busy poll: GLU busy held 1 for 5 polls -> exactly 6 control reads before data; no error.
- Timeout: busy stuck 1 with POLL_LIMIT = 4 -> 4 polls, then done with error = 1, no data access. Error clears on next acceptance.
- ph0_en every 14th clock, write len 3 -> every select pulse coincides with ph0_en, exactly one per ph0_en. wdata_ack ×4; data bytes follow the client's sequence.
- Reset asserted during the second DATA byte -> select = 0 the next cycle, req_ready = 1, no done. A new request then completes normally.
